// File: rtl/imem_resp.sv
// imem_resp: instruction-memory responder serving fetch requests after a fixed wait-state count.
//   Ports: clk_i/rst_i (sync active-high reset);
//          req_valid_i/req_ready_o/req_addr_i carry the fetch request;
//          rsp_valid_o/rsp_ready_i/rsp_instr_o/rsp_err_o carry the response;
//          ld_we_i/ld_addr_i/ld_data_i form the preload port, which works in every state and during reset.
//   Optional: define IMEM_ALIGN_CHECK_EN to make addresses with addr[1:0]!=0 fault.
module imem_resp #(
   parameter logic [31:0] BASE_ADDR   = 32'h80000000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [31:0]                    req_addr_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [31:0]                    rsp_instr_o,
   output logic                           rsp_err_o,
   input  logic                           ld_we_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr_i,
   input  logic [31:0]                    ld_data_i
);
   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
   localparam logic [2:0]  CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      r_state, w_next;
   logic [31:0] r_addr, r_instr;
   logic        r_err;
   logic [2:0]  r_cnt;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_accept, w_lookup, w_in_range, w_misal, w_fault;
   logic [31:0]   w_lk_addr, w_off, w_word;
   logic [AW-1:0] w_idx;

   assign req_ready_o = (r_state == IDLE) && !rst_i;
   assign w_accept    = req_valid_i && req_ready_o;
   assign rsp_valid_o = (r_state == RESP);
   assign rsp_instr_o = r_instr;
   assign rsp_err_o   = r_err;

   // With zero wait states the lookup uses the live request address in the accepting cycle.
   assign w_lk_addr  = (r_state == IDLE) ? req_addr_i : r_addr;
   // Unsigned offset: addresses below the base wrap to huge values, so one compare covers both bounds.
   assign w_off      = w_lk_addr - BASE_ADDR;
   assign w_in_range = w_off < SPAN;
   assign w_idx      = w_off[AW+1:2];
`ifdef IMEM_ALIGN_CHECK_EN
   assign w_misal = |w_lk_addr[1:0];
`else
   assign w_misal = 1'b0;
`endif
   assign w_fault  = !w_in_range || w_misal;
   // Write-first: a same-cycle load to the looked-up word is forwarded.
   assign w_word   = (ld_we_i && ld_addr_i == w_idx) ? ld_data_i : r_mem[w_idx];
   assign w_lookup = (r_state == IDLE) ? (w_accept && (LATENCY == 0)) : (r_state == WAIT && r_cnt == 3'd0);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = w_accept ? ((LATENCY == 0) ? RESP : WAIT) : IDLE;
         WAIT:    w_next = (r_cnt == 3'd0) ? RESP : WAIT;
         RESP:    w_next = rsp_ready_i ? IDLE : RESP;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
         r_addr  <= 32'h0;
         r_instr <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr <= req_addr_i;
            r_cnt  <= CNT_INIT;
         end else if (r_state == WAIT && r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (w_lookup) begin
            r_instr <= w_fault ? 32'h0 : w_word;
            r_err   <= w_fault;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (ld_we_i) r_mem[ld_addr_i] <= ld_data_i;
   end
endmodule

// File: tb/tb_imem_resp.sv
// tb_imem_resp: randomized self-checking bench for imem_resp at LATENCY 1, 3 and 0 against a transaction-level model.
module tb_imem_resp;
   localparam logic [31:0] BASE  = 32'h80000000;
   localparam int          DEPTH = 1024;

   logic        clk = 0, rst = 1;
   logic        req_valid [3], rdy [3], rsp_valid [3], rsp_ready [3], rsp_err [3];
   logic [31:0] req_addr [3], rsp_instr [3];
   logic        d_we = 0, r_we = 0, rnd_ld = 0, ld_we;
   logic [9:0]  d_addr = 0, r_addr = 0, ld_addr;
   logic [31:0] d_data = 0, r_data = 0, ld_data;
   int          n_chk = 0, n_pass = 0, cyc = 0;
   bit          chk_en = 0;

   assign ld_we   = rnd_ld ? r_we : d_we;
   assign ld_addr = rnd_ld ? r_addr : d_addr;
   assign ld_data = rnd_ld ? r_data : d_data;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gi
      imem_resp #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 0))) u (
         .clk_i(clk), .rst_i(rst),
         .req_valid_i(req_valid[g]), .req_ready_o(rdy[g]), .req_addr_i(req_addr[g]),
         .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]),
         .rsp_instr_o(rsp_instr[g]), .rsp_err_o(rsp_err[g]),
         .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
   end

   function automatic int lat_of(input int g);
      return g == 0 ? 1 : (g == 1 ? 3 : 0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
   endtask

   // Model: a fetch accepted in cycle a is valid from cycle a+L+1 until the handshake; data is the
   // memory image at the end of cycle a+L, including any load performed in that cycle.
   logic [31:0] mem_m [DEPTH];
   bit          busy [3], me [3];
   int          acc [3];
   logic [31:0] ma [3], mi [3];
   bit          ev;

   function automatic void look(input logic [31:0] a, output logic [31:0] d, output logic e);
      longint unsigned la;
      la = 64'(a);
      e  = !(la >= 64'(BASE) && la < 64'(BASE) + 64'(4 * DEPTH));
`ifdef IMEM_ALIGN_CHECK_EN
      if (a[1:0] != 2'b00) e = 1'b1;
`endif
      d = 32'h0;
      if (!e) d = mem_m[int'((a - BASE) / 4)];
   endfunction

   always @(posedge clk) begin
      if (ld_we) mem_m[ld_addr] = ld_data;
      for (int g = 0; g < 3; g++) begin
         if (rst) begin
            busy[g] = 0; mi[g] = 0; me[g] = 0;
         end else begin
            if (busy[g] && cyc >= acc[g] + lat_of(g) + 1) begin
               if (rsp_ready[g]) busy[g] = 0;
            end else if (!busy[g] && req_valid[g]) begin
               busy[g] = 1; acc[g] = cyc; ma[g] = req_addr[g];
            end
            if (busy[g] && cyc == acc[g] + lat_of(g)) look(ma[g], mi[g], me[g]);
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < 3; g++) begin
            ev = busy[g] && cyc >= acc[g] + lat_of(g) + 1;
            chk($sformatf("valid[%0d]", g), rsp_valid[g], ev);
            chk($sformatf("req_ready[%0d]", g), rdy[g], !busy[g] && !rst);
            if (ev) begin
               chk($sformatf("instr[%0d]", g), rsp_instr[g], mi[g]);
               chk($sformatf("err[%0d]", g), rsp_err[g], me[g]);
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      r_we   = rnd_ld && ($urandom % 2 == 0);
      r_addr = 10'($urandom % 8);
      r_data = $urandom;
   end

   task automatic fetch(input int g, input logic [31:0] a, input int hold, input bit ld,
                        input logic [31:0] ldat, output logic [31:0] ins, output logic er, output int lat);
      int t;
      @(posedge clk); #1;
      req_valid[g] = 1; req_addr[g] = a; rsp_ready[g] = 0;
      if (ld) begin d_we = 1; d_addr = 10'(((a - BASE) >> 2)); d_data = ldat; end
      t = 0;
      do begin @(negedge clk); t++; end while (!rdy[g] && t < 50);
      chk("accept", rdy[g], 1);
      @(posedge clk); #1;
      req_valid[g] = 0; d_we = 0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid[g] && lat < 50);
      chk("rsp_arrives", rsp_valid[g], 1);
      ins = rsp_instr[g]; er = rsp_err[g];
      repeat (hold) @(negedge clk);
      @(posedge clk); #1 rsp_ready[g] = 1;
      @(posedge clk); #1 rsp_ready[g] = 0;
   endtask

   logic [31:0] ins;
   logic        er;
   int          lat;

   initial begin
      for (int g = 0; g < 3; g++) begin
         req_valid[g] = 0; req_addr[g] = 0; rsp_ready[g] = 0;
      end
      @(posedge clk); #1 chk_en = 1;
      for (int i = 0; i < DEPTH; i++) begin
         d_we = 1; d_addr = 10'(i); d_data = (i == 0) ? 32'h00100093 : $urandom;
         @(posedge clk); #1;
      end
      d_we = 0; rst = 0;
      repeat (2) @(posedge clk);

      fetch(0, 32'h80000000, 0, 0, 0, ins, er, lat);
      chk("l1_word0", ins, 32'h00100093); chk("l1_err", er, 0); chk("l1_lat", lat, 2);

      fetch(1, 32'h80000000, 5, 0, 0, ins, er, lat);
      chk("l3_word0", ins, 32'h00100093); chk("l3_lat", lat, 4);
      @(negedge clk) chk("l3_ready_after", rdy[1], 1);

      fetch(0, 32'h80001000, 0, 0, 0, ins, er, lat);
      chk("past_end_err", er, 1); chk("past_end_instr", ins, 0);
      fetch(0, 32'h7FFFFFFC, 0, 0, 0, ins, er, lat);
      chk("below_base_err", er, 1); chk("below_base_instr", ins, 0);
      fetch(0, 32'h80000FFC, 1, 0, 0, ins, er, lat);
      chk("last_word_err", er, 0); chk("last_word", ins, mem_m[DEPTH-1]);

      fetch(2, 32'h80000004, 0, 1, 32'hDEADBEEF, ins, er, lat);
      chk("l0_fwd", ins, 32'hDEADBEEF); chk("l0_lat", lat, 1); chk("l0_err", er, 0);

      @(posedge clk); #1 req_valid[1] = 1; req_addr[1] = BASE;
      @(posedge clk); #1 req_valid[1] = 0;
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("rst_valid", rsp_valid[1], 0); chk("rst_instr", rsp_instr[1], 0);
      chk("rst_err", rsp_err[1], 0); chk("rst_ready", rdy[1], 1);
      repeat (8) @(negedge clk);
      fetch(1, 32'h80000000, 0, 0, 0, ins, er, lat);
      chk("post_rst_word0", ins, 32'h00100093);

      fetch(0, 32'h80000006, 0, 0, 0, ins, er, lat);
`ifdef IMEM_ALIGN_CHECK_EN
      chk("misal_err", er, 1); chk("misal_instr", ins, 0);
`else
      chk("misal_err", er, 0); chk("misal_instr", ins, 32'hDEADBEEF);
`endif

      rnd_ld = 1;
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         int sel;
         sel = int'($urandom % 8);
         a = (sel == 0) ? BASE + 32'(4 * DEPTH) :
             (sel == 1) ? BASE - 32'd4 :
             (sel == 2) ? BASE + 32'(4 * (DEPTH - 1)) :
             (sel == 3) ? BASE + 32'($urandom % 32) :
                          BASE + 32'(4 * ($urandom % 8));
         fetch(int'($urandom % 3), a, int'($urandom % 4), 0, 0, ins, er, lat);
      end
      rnd_ld = 0;
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
